// File: rtl/fsm_ctrl_mw.sv
// Control FSM for the simple RISC datapath: fetch, ALU/MOV, LDR/STR, HALT and
// an illegal-opcode/memory-timeout trap, with Moore outputs decoded from state.
module fsm_ctrl_mw #(
  parameter int MEM_WAIT   = 1,
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic       mem_ready,
  output logic [2:0] nsel,
  output logic [3:0] vsel,
  output logic       asel,
  output logic       bsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       write,
  output logic [1:0] ALUop,
  output logic       reset_pc,
  output logic       load_pc,
  output logic       addr_sel,
  output logic       load_ir,
  output logic       load_addr,
  output logic [2:0] mem_cmd,
  output logic       halted,
  output logic       err
);

  typedef enum logic [4:0] {
    S_RST   = 5'd0,  S_IF1   = 5'd1,  S_IF2   = 5'd2,  S_UPDPC = 5'd3,
    S_DEC   = 5'd4,  S_GETA  = 5'd5,  S_GETB  = 5'd6,  S_EXEC  = 5'd7,
    S_WRC   = 5'd8,  S_MOVI  = 5'd9,  S_MGETB = 5'd10, S_MSHOW = 5'd11,
    S_LADR  = 5'd12, S_LCALC = 5'd13, S_LDAR  = 5'd14, S_LRD   = 5'd15,
    S_LWB   = 5'd16, S_SADR  = 5'd17, S_SCALC = 5'd18, S_SDAR  = 5'd19,
    S_SGETB = 5'd20, S_SPASS = 5'd21, S_SWR   = 5'd22, S_HALT  = 5'd23,
    S_ERR   = 5'd24
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             ready_s;
  logic             wait_state_s;
  logic             timeout_s;

  assign ready_s      = (MEM_WAIT == 0) ? 1'b1 : mem_ready;
  assign wait_state_s = (state_r == S_IF1) || (state_r == S_LRD) || (state_r == S_SWR);
  // ready on the limit cycle takes priority, so timeout only matters when ready is low
  assign timeout_s    = wait_state_s && !ready_s && (cnt_r == LIMIT_M1);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_RST;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Wait counter: cleared on every state change, counts stalled cycles otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (state_next_s != state_r) begin
      cnt_r <= '0;
    end else if (wait_state_s && !ready_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = S_ERR;
    case (state_r)
      S_RST:   state_next_s = S_IF1;
      S_IF1:   begin
        if (ready_s)        state_next_s = S_IF2;
        else if (timeout_s) state_next_s = S_ERR;
        else                state_next_s = S_IF1;
      end
      S_IF2:   state_next_s = S_UPDPC;
      S_UPDPC: state_next_s = S_DEC;
      S_DEC:   begin
        case (opcode)
          3'b101:  state_next_s = S_GETA;
          3'b110:  begin
            if (op == 2'b10)      state_next_s = S_MOVI;
            else if (op == 2'b00) state_next_s = S_MGETB;
            else                  state_next_s = S_ERR;
          end
          3'b011:  state_next_s = S_LADR;
          3'b100:  state_next_s = S_SADR;
          3'b111:  state_next_s = S_HALT;
          default: state_next_s = S_ERR;
        endcase
      end
      S_GETA:  state_next_s = S_GETB;
      S_GETB:  state_next_s = S_EXEC;
      S_EXEC:  begin
        if (op == 2'b01) state_next_s = S_IF1;
        else             state_next_s = S_WRC;
      end
      S_WRC:   state_next_s = S_IF1;
      S_MOVI:  state_next_s = S_IF1;
      S_MGETB: state_next_s = S_MSHOW;
      S_MSHOW: state_next_s = S_WRC;
      S_LADR:  state_next_s = S_LCALC;
      S_LCALC: state_next_s = S_LDAR;
      S_LDAR:  state_next_s = S_LRD;
      S_LRD:   begin
        if (ready_s)        state_next_s = S_LWB;
        else if (timeout_s) state_next_s = S_ERR;
        else                state_next_s = S_LRD;
      end
      S_LWB:   state_next_s = S_IF1;
      S_SADR:  state_next_s = S_SCALC;
      S_SCALC: state_next_s = S_SDAR;
      S_SDAR:  state_next_s = S_SGETB;
      S_SGETB: state_next_s = S_SPASS;
      S_SPASS: state_next_s = S_SWR;
      S_SWR:   begin
        if (ready_s)        state_next_s = S_IF1;
        else if (timeout_s) state_next_s = S_ERR;
        else                state_next_s = S_SWR;
      end
      S_HALT:  state_next_s = S_HALT;
      S_ERR:   state_next_s = S_ERR;
      default: state_next_s = S_ERR;
    endcase
  end

  // Moore output decode
  always_comb begin
    nsel      = 3'b001;
    vsel      = 4'b0001;
    asel      = 1'b0;
    bsel      = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    write     = 1'b0;
    ALUop     = 2'b00;
    reset_pc  = 1'b0;
    load_pc   = 1'b0;
    addr_sel  = 1'b0;
    load_ir   = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = 3'b001;
    halted    = 1'b0;
    err       = 1'b0;
    case (state_r)
      S_RST:   begin reset_pc = 1'b1; load_pc = 1'b1; end
      S_IF1:   begin addr_sel = 1'b1; mem_cmd = 3'b010; end
      S_IF2:   begin addr_sel = 1'b1; mem_cmd = 3'b010; load_ir = 1'b1; end
      S_UPDPC: load_pc = 1'b1;
      S_DEC:   load_pc = 1'b0;
      S_GETA, S_LADR, S_SADR: begin nsel = 3'b001; loada = 1'b1; end
      S_GETB, S_MGETB:        begin nsel = 3'b100; loadb = 1'b1; end
      S_EXEC:  begin
        loadc = 1'b1;
        ALUop = op;
        loads = (op == 2'b01);
      end
      S_WRC:   begin write = 1'b1; nsel = 3'b010; vsel = 4'b0001; end
      S_MOVI:  begin write = 1'b1; nsel = 3'b001; vsel = 4'b0100; end
      S_MSHOW, S_SPASS:       begin asel = 1'b1; loadc = 1'b1; ALUop = 2'b00; end
      S_LCALC, S_SCALC:       begin bsel = 1'b1; loadc = 1'b1; ALUop = 2'b00; end
      S_LDAR, S_SDAR:         load_addr = 1'b1;
      S_LRD:   begin addr_sel = 1'b0; mem_cmd = 3'b010; end
      S_LWB:   begin
        mem_cmd = 3'b010;
        write   = 1'b1;
        nsel    = 3'b010;
        vsel    = 4'b0010;
      end
      S_SGETB: begin nsel = 3'b010; loadb = 1'b1; end
      S_SWR:   begin addr_sel = 1'b0; mem_cmd = 3'b100; end
      S_HALT:  halted = 1'b1;
      S_ERR:   begin halted = 1'b1; err = 1'b1; end
      default: halted = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_fsm_ctrl_mw.sv
// Directed bench for fsm_ctrl_mw: every instruction flow, memory wait/timeout,
// HALT/ERR and mid-instruction reset, plus a MEM_WAIT=0 instance.
module tb_fsm_ctrl_mw;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] opcode = 3'b101;
  logic [1:0] op = 2'b00;
  logic mem_ready = 1'b1;
  logic mem_ready0 = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // output bundle: {nsel,vsel,asel,bsel,loada,loadb,loadc,loads,write,ALUop,
  //                 reset_pc,load_pc,addr_sel,load_ir,load_addr,mem_cmd,halted,err}
  function automatic logic [25:0] pat(input logic [2:0] ns, input logic [3:0] vs,
                                      input logic [6:0] ctl, input logic [1:0] alu,
                                      input logic [4:0] pcs, input logic [2:0] mc,
                                      input logic [1:0] he);
    return {ns, vs, ctl, alu, pcs, mc, he};
  endfunction

  localparam logic [25:0] P_RST   = pat(3'b001, 4'b0001, 7'b0000000, 2'b00, 5'b11000, 3'b001, 2'b00);
  localparam logic [25:0] P_IF1   = pat(3'b001, 4'b0001, 7'b0000000, 2'b00, 5'b00100, 3'b010, 2'b00);
  localparam logic [25:0] P_IF2   = pat(3'b001, 4'b0001, 7'b0000000, 2'b00, 5'b00110, 3'b010, 2'b00);
  localparam logic [25:0] P_UPD   = pat(3'b001, 4'b0001, 7'b0000000, 2'b00, 5'b01000, 3'b001, 2'b00);
  localparam logic [25:0] P_DEC   = pat(3'b001, 4'b0001, 7'b0000000, 2'b00, 5'b00000, 3'b001, 2'b00);
  localparam logic [25:0] P_GETA  = pat(3'b001, 4'b0001, 7'b0010000, 2'b00, 5'b00000, 3'b001, 2'b00);
  localparam logic [25:0] P_GETB  = pat(3'b100, 4'b0001, 7'b0001000, 2'b00, 5'b00000, 3'b001, 2'b00);
  localparam logic [25:0] P_EXADD = pat(3'b001, 4'b0001, 7'b0000100, 2'b00, 5'b00000, 3'b001, 2'b00);
  localparam logic [25:0] P_EXCMP = pat(3'b001, 4'b0001, 7'b0000110, 2'b01, 5'b00000, 3'b001, 2'b00);
  localparam logic [25:0] P_WRC   = pat(3'b010, 4'b0001, 7'b0000001, 2'b00, 5'b00000, 3'b001, 2'b00);
  localparam logic [25:0] P_MOVI  = pat(3'b001, 4'b0100, 7'b0000001, 2'b00, 5'b00000, 3'b001, 2'b00);
  localparam logic [25:0] P_SHOW  = pat(3'b001, 4'b0001, 7'b1000100, 2'b00, 5'b00000, 3'b001, 2'b00);
  localparam logic [25:0] P_CALC  = pat(3'b001, 4'b0001, 7'b0100100, 2'b00, 5'b00000, 3'b001, 2'b00);
  localparam logic [25:0] P_DAR   = pat(3'b001, 4'b0001, 7'b0000000, 2'b00, 5'b00001, 3'b001, 2'b00);
  localparam logic [25:0] P_LRD   = pat(3'b001, 4'b0001, 7'b0000000, 2'b00, 5'b00000, 3'b010, 2'b00);
  localparam logic [25:0] P_LWB   = pat(3'b010, 4'b0010, 7'b0000001, 2'b00, 5'b00000, 3'b010, 2'b00);
  localparam logic [25:0] P_SGETB = pat(3'b010, 4'b0001, 7'b0001000, 2'b00, 5'b00000, 3'b001, 2'b00);
  localparam logic [25:0] P_SWR   = pat(3'b001, 4'b0001, 7'b0000000, 2'b00, 5'b00000, 3'b100, 2'b00);
  localparam logic [25:0] P_HALT  = pat(3'b001, 4'b0001, 7'b0000000, 2'b00, 5'b00000, 3'b001, 2'b10);
  localparam logic [25:0] P_ERR   = pat(3'b001, 4'b0001, 7'b0000000, 2'b00, 5'b00000, 3'b001, 2'b11);

  logic [2:0] nsel, mem_cmd, nsel0, mem_cmd0;
  logic [3:0] vsel, vsel0;
  logic [1:0] alu_op, alu_op0;
  logic asel, bsel, loada, loadb, loadc, loads, write;
  logic reset_pc, load_pc, addr_sel, load_ir, load_addr, halted, err;
  logic asel0, bsel0, loada0, loadb0, loadc0, loads0, write0;
  logic reset_pc0, load_pc0, addr_sel0, load_ir0, load_addr0, halted0, err0;
  logic [25:0] ov, ov0;

  fsm_ctrl_mw #(.MEM_WAIT(1), .WAIT_LIMIT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .mem_ready(mem_ready),
    .nsel(nsel), .vsel(vsel), .asel(asel), .bsel(bsel), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .write(write), .ALUop(alu_op), .reset_pc(reset_pc),
    .load_pc(load_pc), .addr_sel(addr_sel), .load_ir(load_ir), .load_addr(load_addr),
    .mem_cmd(mem_cmd), .halted(halted), .err(err)
  );

  fsm_ctrl_mw #(.MEM_WAIT(0), .WAIT_LIMIT(4), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .mem_ready(mem_ready0),
    .nsel(nsel0), .vsel(vsel0), .asel(asel0), .bsel(bsel0), .loada(loada0), .loadb(loadb0),
    .loadc(loadc0), .loads(loads0), .write(write0), .ALUop(alu_op0), .reset_pc(reset_pc0),
    .load_pc(load_pc0), .addr_sel(addr_sel0), .load_ir(load_ir0), .load_addr(load_addr0),
    .mem_cmd(mem_cmd0), .halted(halted0), .err(err0)
  );

  assign ov  = {nsel, vsel, asel, bsel, loada, loadb, loadc, loads, write, alu_op,
                reset_pc, load_pc, addr_sel, load_ir, load_addr, mem_cmd, halted, err};
  assign ov0 = {nsel0, vsel0, asel0, bsel0, loada0, loadb0, loadc0, loads0, write0, alu_op0,
                reset_pc0, load_pc0, addr_sel0, load_ir0, load_addr0, mem_cmd0, halted0, err0};

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [25:0] e);
    tick();
    check_value(tag, 32'(ov), 32'(e));
  endtask

  // asynchronous reset pulse, then release and expect IF1 on the first edge
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check_value({tag, "_rst"}, 32'(ov), 32'(P_RST));
    reset = 1'b1;
    step({tag, "_if1"}, P_IF1);
  endtask

  task automatic fetch(input string tag);
    step({tag, "_if2"}, P_IF2);
    step({tag, "_upd"}, P_UPD);
    step({tag, "_dec"}, P_DEC);
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    check_value("reset_state", 32'(ov), 32'(P_RST));
    check_value("reset_state0", 32'(ov0), 32'(P_RST));
    tick();
    check_value("reset_hold", 32'(ov), 32'(P_RST));
    reset = 1'b1;

    // ADD; the MEM_WAIT=0 instance must fetch identically with mem_ready low
    opcode = 3'b101; op = 2'b00;
    step("add_if1", P_IF1);
    check_value("nw_if1", 32'(ov0), 32'(P_IF1));
    step("add_if2", P_IF2);
    check_value("nw_if2", 32'(ov0), 32'(P_IF2));
    step("add_upd", P_UPD);
    check_value("nw_upd", 32'(ov0), 32'(P_UPD));
    step("add_dec", P_DEC);
    check_value("nw_dec", 32'(ov0), 32'(P_DEC));
    step("add_geta", P_GETA);
    check_value("nw_geta", 32'(ov0), 32'(P_GETA));
    step("add_getb", P_GETB);
    step("add_exec", P_EXADD);
    step("add_wrc", P_WRC);
    step("add_back", P_IF1);

    // CMP: no writeback, 7 cycles
    op = 2'b01;
    fetch("cmp");
    step("cmp_geta", P_GETA);
    step("cmp_getb", P_GETB);
    step("cmp_exec", P_EXCMP);
    step("cmp_back", P_IF1);

    // MOV immediate
    opcode = 3'b110; op = 2'b10;
    fetch("movi");
    step("movi_st", P_MOVI);
    step("movi_back", P_IF1);

    // MOV register
    op = 2'b00;
    fetch("movr");
    step("movr_getb", P_GETB);
    step("movr_show", P_SHOW);
    step("movr_wrc", P_WRC);
    step("movr_back", P_IF1);

    // LDR with three stalled cycles in LRD
    opcode = 3'b011;
    fetch("ldr");
    step("ldr_adr", P_GETA);
    step("ldr_calc", P_CALC);
    step("ldr_dar", P_DAR);
    step("ldr_rd0", P_LRD);
    mem_ready = 1'b0;
    opcode = 3'b000;
    step("ldr_rd1", P_LRD);
    step("ldr_rd2", P_LRD);
    step("ldr_rd3", P_LRD);
    mem_ready = 1'b1;
    step("ldr_wb", P_LWB);
    step("ldr_back", P_IF1);

    // STR with one stall, then reset while writing
    opcode = 3'b100;
    fetch("str");
    step("str_adr", P_GETA);
    step("str_calc", P_CALC);
    step("str_dar", P_DAR);
    step("str_getb", P_SGETB);
    step("str_pass", P_SHOW);
    step("str_wr0", P_SWR);
    mem_ready = 1'b0;
    step("str_wr1", P_SWR);
    do_reset("str");
    mem_ready = 1'b1;

    // HALT is absorbing
    opcode = 3'b111;
    fetch("halt");
    step("halt_st", P_HALT);
    opcode = 3'b101;
    step("halt_hold", P_HALT);
    do_reset("halt");

    // illegal opcodes trap
    opcode = 3'b000;
    fetch("ill");
    step("ill_err", P_ERR);
    do_reset("ill");
    opcode = 3'b110; op = 2'b11;
    fetch("ill2");
    step("ill2_err", P_ERR);

    // fetch timeout after 4 stalled IF1 cycles
    mem_ready = 1'b0;
    do_reset("to");
    step("to_w1", P_IF1);
    step("to_w2", P_IF1);
    step("to_w3", P_IF1);
    step("to_err", P_ERR);
    mem_ready = 1'b1;
    step("to_hold", P_ERR);

    // ready on the limit cycle wins over the trap
    mem_ready = 1'b0;
    do_reset("lim");
    step("lim_w1", P_IF1);
    step("lim_w2", P_IF1);
    step("lim_w3", P_IF1);
    mem_ready = 1'b1;
    step("lim_if2", P_IF2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fsm_ctrl_mw.md
Name: fsm_ctrl_mw

Overview:
- Next-generation control FSM for the simple RISC datapath.
- Adds LDR/STR, MOV with shifted register, HALT, and an illegal-opcode trap on top of the ALU/MOV flow.
- Adds a parametrised memory-ready handshake with timeout, so fetch and data accesses tolerate variable-latency memory.
- Sits between the instruction decoder (opcode/op) and datapath/PC/memory-address logic; drives every datapath load/select.

Parameters:
- MEM_WAIT, 1: 1 = memory states hold until mem_ready; 0 = mem_ready ignored and every access takes one cycle.
- WAIT_LIMIT, 15: maximum consecutive mem_ready-low cycles in one memory state before trapping (1..255).
- CNT_W, 8: wait-counter width; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  3  IR[15:13].
- op  in  2  IR[12:11].
- mem_ready  in  1  memory completes the current read/write this cycle.
- nsel  out  3  one-hot register select: 001 Rn, 010 Rd, 100 Rm.
- vsel  out  4  one-hot writeback select: 0001 C, 0010 mdata, 0100 sximm8, 1000 PC.
- asel, bsel  out  1  each; ALU A := 0 when asel=1; ALU B := sximm5 when bsel=1.
- loada, loadb, loadc, loads, write  out  1  each; datapath enables.
- ALUop  out  2  00 ADD, 01 SUB/CMP, 10 AND, 11 MVN.
- reset_pc, load_pc, addr_sel, load_ir, load_addr  out  1  each; PC, address mux (1 = PC), IR and data-address register enables.
- mem_cmd  out  3  one-hot: 001 NONE, 010 READ, 100 WRITE.
- halted  out  1  high in HALT or ERR.
- err  out  1  high only in ERR.

Behaviour:
- Outputs are Moore: a combinational decode of the registered state.
- Every output is assigned in every state; default 0, nsel=001, vsel=0001, mem_cmd=001.
- Reset low (async): state=RST immediately. Outputs then: reset_pc=1, load_pc=1, all other enables 0, mem_cmd=001, halted=0, err=0, wait counter=0.
- Fetch:
  - RST -> IF1 (addr_sel=1, READ).
  - IF1 -> IF2 when ready (addr_sel=1, READ, load_ir=1).
  - IF2 -> UPDPC (load_pc=1) -> DEC.
- "ready" means mem_ready=1 if MEM_WAIT=1, else constant 1.
- DEC dispatch:
  - 101 -> GETA.
  - 110 op=10 -> MOVI.
  - 110 op=00 -> MGETB.
  - 011 -> LADR.
  - 100 -> SADR.
  - 111 -> HALT.
  - anything else -> ERR.
- ALU path:
  - GETA (nsel=001, loada).
  - GETB (nsel=100, loadb).
  - EXEC (loadc, ALUop=op).
  - If op=01 (CMP): EXEC also asserts loads, then -> IF1.
  - Otherwise EXEC -> WRC (write, nsel=010, vsel=0001) -> IF1.
- MOVI: write, nsel=001, vsel=0100 -> IF1.
- MOV reg: MGETB (nsel=100, loadb) -> MSHOW (asel=1, loadc, ALUop=00) -> WRC.
- LDR path:
  - LADR (nsel=001, loada).
  - LCALC (bsel=1, ALUop=00, loadc).
  - LDAR (load_addr).
  - LRD (addr_sel=0, READ); holds until ready.
  - LWB (addr_sel=0, READ, write, nsel=010, vsel=0010) -> IF1.
- STR path:
  - SADR (nsel=001, loada).
  - SCALC (bsel=1, loadc).
  - SDAR (load_addr).
  - SGETB (nsel=010, loadb).
  - SPASS (asel=1, ALUop=00, loadc).
  - SWR (addr_sel=0, WRITE); holds until ready -> IF1.
- Wait counter:
  - Cleared on entry to IF1, LRD and SWR.
  - Increments each cycle spent in those states with ready=0.
  - When it reaches WAIT_LIMIT with ready still 0 -> ERR.
  - mem_ready=1 on the limit cycle wins: normal transition, no trap.
- HALT and ERR:
  - Both are absorbing; only reset exits them.
  - Both: mem_cmd=001, all enables 0, halted=1; ERR additionally err=1.
- Inputs sampled only in DEC, EXEC (op) and the wait states. Changes to opcode/op elsewhere have no effect.
- Reset asserted mid-instruction: next cycle is RST with no write/loadc/mem command. Instruction side effects already committed stay committed.
- Unreachable state encodings -> ERR.

Test Plan:
- Reset low during SWR with mem_cmd=100 -> same-cycle state RST, mem_cmd=001, reset_pc=1, load_pc=1. Release -> IF1 on first edge.
- MEM_WAIT=1, mem_ready held 1, opcode=101 op=00 -> IF1, IF2, UPDPC, DEC, GETA, GETB, EXEC(ALUop=00, loadc), WRC(write, nsel=010). 8 cycles back to IF1.
- opcode=101 op=01 -> EXEC has loads=1, loadc=1, no WRC, and returns to IF1 after 7 cycles.
- LDR with mem_ready low for 3 cycles in LRD -> LRD held 4 cycles with mem_cmd=010, addr_sel=0, then LWB with vsel=0010, write=1.
- WAIT_LIMIT=4, mem_ready stuck 0 in IF1 -> ERR after 4 wait cycles; err=1, halted=1, mem_cmd=001; stays until reset.
- opcode=111 -> HALT with halted=1, err=0. opcode=000 -> ERR.
- MEM_WAIT=0 with mem_ready=0 -> fetch still completes in 4 cycles.
